// File: rtl/cond_unit.sv
// Conditional-execution stage for the multicycle ARM control path.
// Holds NZCV flags and a registered condition-pass bit; gates FSM write enables.
module cond_unit #(
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       NextPC,
   input  logic       Branch,
   input  logic       RegW,
   input  logic       MemW,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags,
   output logic       CondExReg
);

   logic [1:0] nz;
   logic [1:0] cv;
   logic       n;
   logic       z;
   logic       c;
   logic       v;
   logic       cond_ex;
   logic [1:0] flag_write;

   assign Flags = {nz, cv};
   assign n     = nz[1];
   assign z     = nz[0];
   assign c     = cv[1];
   assign v     = cv[0];

   // Evaluated against registered flags only; default keeps X off the output.
   always_comb begin
      cond_ex = 1'b1;
      case (Cond)
         4'b0000: cond_ex = z;
         4'b0001: cond_ex = ~z;
         4'b0010: cond_ex = c;
         4'b0011: cond_ex = ~c;
         4'b0100: cond_ex = n;
         4'b0101: cond_ex = ~n;
         4'b0110: cond_ex = v;
         4'b0111: cond_ex = ~v;
         4'b1000: cond_ex = c & ~z;
         4'b1001: cond_ex = ~c | z;
         4'b1010: cond_ex = (n == v);
         4'b1011: cond_ex = (n != v);
         4'b1100: cond_ex = ~z & (n == v);
         4'b1101: cond_ex = z | (n != v);
         default: cond_ex = 1'b1;
      endcase
   end

   assign flag_write = FlagW & {2{cond_ex}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nz <= FLAG_RESET[3:2];
      end else if (flag_write[1]) begin
         nz <= ALUFlags[3:2];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cv <= FLAG_RESET[1:0];
      end else if (flag_write[0]) begin
         cv <= ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         CondExReg <= 1'b0;
      end else begin
         CondExReg <= cond_ex;
      end
   end

   assign PCWrite  = NextPC | (Branch & CondExReg);
   assign RegWrite = RegW & CondExReg;
   assign MemWrite = MemW & CondExReg;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit against a behavioural NZCV/condition model.
module tb_cond_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       NextPC;
   logic       Branch;
   logic       RegW;
   logic       MemW;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic [3:0] Flags;
   logic       CondExReg;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0] m_flags;
   logic       m_cex;

   cond_unit #(.FLAG_RESET(4'b0000)) dut (
      .clk(clk),
      .reset(reset),
      .Cond(Cond),
      .ALUFlags(ALUFlags),
      .FlagW(FlagW),
      .NextPC(NextPC),
      .Branch(Branch),
      .RegW(RegW),
      .MemW(MemW),
      .PCWrite(PCWrite),
      .RegWrite(RegWrite),
      .MemWrite(MemWrite),
      .Flags(Flags),
      .CondExReg(CondExReg)
   );

   always #5 clk = ~clk;

   // Base condition on Cond[3:1]; Cond[0] inverts it, except for the AL pair.
   function automatic logic cond_pass(input logic [3:0] cd, input logic [3:0] f);
      logic fn, fz, fc, fv, base;
      fn = f[3];
      fz = f[2];
      fc = f[1];
      fv = f[0];
      case (cd[3:1])
         3'd0: base = fz;
         3'd1: base = fc;
         3'd2: base = fn;
         3'd3: base = fv;
         3'd4: base = fc && !fz;
         3'd5: base = (fn == fv);
         3'd6: base = !fz && (fn == fv);
         default: base = 1'b1;
      endcase
      if (cd[3:1] == 3'd7) return 1'b1;
      return base ^ cd[0];
   endfunction

   task automatic tick();
      logic       p;
      logic [3:0] nf;
      p  = cond_pass(Cond, m_flags);
      nf = m_flags;
      if (FlagW[1] && p) nf[3:2] = ALUFlags[3:2];
      if (FlagW[0] && p) nf[1:0] = ALUFlags[1:0];
      @(posedge clk);
      m_flags = nf;
      m_cex   = p;
      #1;
   endtask

   task automatic idle_inputs();
      Cond = 4'b1110;
      ALUFlags = 4'b0000;
      FlagW = 2'b00;
      NextPC = 1'b0;
      Branch = 1'b0;
      RegW = 1'b0;
      MemW = 1'b0;
   endtask

   task automatic set_flags(input logic [3:0] f);
      Cond = 4'b1110;
      FlagW = 2'b11;
      ALUFlags = f;
      tick();
      FlagW = 2'b00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_flags = 4'b0000;
      m_cex = 1'b0;
      #3;
      @(negedge clk);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      do_reset();
      vectors++;
      if (Flags !== m_flags) begin
         miscompares++;
         $display("FAIL reset_flags got=%b exp=%b", Flags, m_flags);
      end
      vectors++;
      if (CondExReg !== m_cex) begin
         miscompares++;
         $display("FAIL reset_cex got=%b exp=%b", CondExReg, m_cex);
      end
      set_flags(4'b1111);
      #2;
      reset = 1'b1;
      NextPC = 1'b1;
      m_flags = 4'b0000;
      m_cex = 1'b0;
      #1;
      vectors++;
      if (Flags !== m_flags || CondExReg !== m_cex) begin
         miscompares++;
         $display("FAIL midrun_reset got=%b/%b exp=%b/%b",
                  Flags, CondExReg, m_flags, m_cex);
      end
      vectors++;
      if (PCWrite !== NextPC) begin
         miscompares++;
         $display("FAIL reset_pcwrite got=%b exp=%b", PCWrite, NextPC);
      end
      @(negedge clk);
      reset = 1'b0;
      NextPC = 1'b0;
      RegW = 1'b1;
      #1;
      vectors++;
      if (RegWrite !== (RegW & m_cex)) begin
         miscompares++;
         $display("FAIL post_reset_regwrite got=%b exp=%b", RegWrite, RegW & m_cex);
      end
      RegW = 1'b0;
   endtask

   task automatic test_eq_ne();
      set_flags(4'b0100);
      Cond = 4'b0000;
      tick();
      RegW = 1'b1;
      #1;
      vectors++;
      if (RegWrite !== (RegW & m_cex)) begin
         miscompares++;
         $display("FAIL eq_regwrite got=%b exp=%b", RegWrite, RegW & m_cex);
      end
      RegW = 1'b0;
      Cond = 4'b0001;
      tick();
      RegW = 1'b1;
      MemW = 1'b1;
      #1;
      vectors++;
      if (RegWrite !== (RegW & m_cex) || MemWrite !== (MemW & m_cex)) begin
         miscompares++;
         $display("FAIL ne_writes got=%b%b exp=%b%b",
                  RegWrite, MemWrite, RegW & m_cex, MemW & m_cex);
      end
      RegW = 1'b0;
      MemW = 1'b0;
   endtask

   task automatic test_flag_halves();
      do_reset();
      Cond = 4'b1110;
      FlagW = 2'b10;
      ALUFlags = 4'b1011;
      tick();
      vectors++;
      if (Flags !== m_flags) begin
         miscompares++;
         $display("FAIL flagw_nz got=%b exp=%b", Flags, m_flags);
      end
      FlagW = 2'b01;
      tick();
      vectors++;
      if (Flags !== m_flags) begin
         miscompares++;
         $display("FAIL flagw_cv got=%b exp=%b", Flags, m_flags);
      end
      FlagW = 2'b00;
   endtask

   task automatic test_flag_blocked();
      set_flags(4'b0011);
      Cond = 4'b0000;
      FlagW = 2'b11;
      ALUFlags = 4'b0100;
      tick();
      vectors++;
      if (Flags !== m_flags) begin
         miscompares++;
         $display("FAIL blocked_flags got=%b exp=%b", Flags, m_flags);
      end
      FlagW = 2'b00;
   endtask

   task automatic test_ge_lt();
      set_flags(4'b1001);
      Cond = 4'b1010;
      tick();
      Branch = 1'b1;
      #1;
      vectors++;
      if (PCWrite !== (NextPC | (Branch & m_cex))) begin
         miscompares++;
         $display("FAIL ge_branch got=%b exp=%b", PCWrite, NextPC | (Branch & m_cex));
      end
      Cond = 4'b1011;
      tick();
      vectors++;
      if (PCWrite !== (NextPC | (Branch & m_cex))) begin
         miscompares++;
         $display("FAIL lt_branch got=%b exp=%b", PCWrite, NextPC | (Branch & m_cex));
      end
      NextPC = 1'b1;
      #1;
      vectors++;
      if (PCWrite !== (NextPC | (Branch & m_cex))) begin
         miscompares++;
         $display("FAIL nextpc_override got=%b exp=%b", PCWrite, 1'b1);
      end
      NextPC = 1'b0;
      Branch = 1'b0;
   endtask

   task automatic test_sweep();
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            set_flags(f[3:0]);
            Cond = c[3:0];
            tick();
            vectors++;
            if (CondExReg !== m_cex) begin
               miscompares++;
               $display("FAIL sweep cond=%b flags=%b got=%b exp=%b",
                        c[3:0], f[3:0], CondExReg, m_cex);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         Cond = 4'($urandom);
         ALUFlags = 4'($urandom);
         FlagW = 2'($urandom);
         NextPC = 1'($urandom);
         Branch = 1'($urandom);
         RegW = 1'($urandom);
         MemW = 1'($urandom);
         #1;
         vectors++;
         if (PCWrite !== (NextPC | (Branch & m_cex)) ||
             RegWrite !== (RegW & m_cex) ||
             MemWrite !== (MemW & m_cex)) begin
            miscompares++;
            $display("FAIL rand_out i=%0d got=%b%b%b exp=%b%b%b", i,
                     PCWrite, RegWrite, MemWrite,
                     NextPC | (Branch & m_cex), RegW & m_cex, MemW & m_cex);
         end
         tick();
         vectors++;
         if (Flags !== m_flags || CondExReg !== m_cex) begin
            miscompares++;
            $display("FAIL rand_state i=%0d got=%b/%b exp=%b/%b", i,
                     Flags, CondExReg, m_flags, m_cex);
         end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      set_flags(4'b0000);
      Cond = 4'b0001;
      FlagW = 2'b11;
      ALUFlags = 4'b0100;
      tick();
      Cond = 4'b0000;
      FlagW = 2'b00;
      tick();
      vectors++;
      if (Flags !== m_flags || CondExReg !== m_cex) begin
         miscompares++;
         $display("FAIL back_to_back got=%b/%b exp=%b/%b",
                  Flags, CondExReg, m_flags, m_cex);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      m_flags = 4'b0000;
      m_cex = 1'b0;
      test_reset();
      test_eq_ne();
      test_flag_halves();
      test_flag_blocked();
      test_ge_lt();
      test_back_to_back();
      test_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
